// File: rtl/clk_div_by_10_pkg.sv
// Shared constants and helpers for the clk_div_by_10 divider.
// Holds the default ratio and the legality check for DIVISOR.
package clk_div_by_10_pkg;

    localparam int DEFAULT_DIVISOR = 10;

    function automatic bit divisor_ok(input int d);
        return (d >= 2) && (d % 2 == 0);
    endfunction

endpackage

// File: rtl/clk_div_by_10_mod_counter.sv
// Wrap-around modulo counter with synchronous reset.
// The wrap flag is high while the count sits at MOD-1.
module mod_counter #(
    parameter int MOD = 10,
    parameter int W   = 4
) (
    input  logic         clk,
    input  logic         reset,
    output logic [W-1:0] cnt,
    output logic         wrap
);

    assign wrap = (cnt == W'(MOD - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (wrap) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/clk_div_by_10.sv
// Even-ratio clock divider: 50% square wave plus terminal-count strobe.
// Output is a registered fabric signal, not a buffered clock.
module clk_div_by_10
    import clk_div_by_10_pkg::*;
#(
    parameter int DIVISOR = DEFAULT_DIVISOR,
    parameter int CNT_W   = $clog2(DIVISOR)
) (
    input  logic clk,
    input  logic reset,
    output logic clk_div_10,
    output logic tc
);

    if (!divisor_ok(DIVISOR)) begin : g_bad_divisor
        $error("clk_div_by_10: DIVISOR must be even and >= 2");
    end

    if ((2 ** CNT_W) < DIVISOR) begin : g_bad_width
        $error("clk_div_by_10: CNT_W too narrow for DIVISOR");
    end

    logic [CNT_W-1:0] cnt;
    logic             wrap;
    logic             half;
    logic             q;

    mod_counter #(
        .MOD (DIVISOR),
        .W   (CNT_W)
    ) u_cnt (
        .clk   (clk),
        .reset (reset),
        .cnt   (cnt),
        .wrap  (wrap)
    );

    assign half = (cnt == CNT_W'(DIVISOR / 2 - 1));

    // Toggle at mid-count and at wrap gives DIVISOR/2 high, DIVISOR/2 low.
    always_ff @(posedge clk) begin
        if (reset) begin
            q  <= 1'b0;
            tc <= 1'b0;
        end else begin
            if (half || wrap) begin
                q <= ~q;
            end
            tc <= wrap;
        end
    end

    assign clk_div_10 = q;

endmodule

// File: tb/tb_clk_div_by_10.sv
// Directed bench for clk_div_by_10: reset, waveform, strobe, mid reset,
// and a ratio sweep at 2, 4 and 16.
module tb_clk_div_by_10;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic q10;
    logic tc10;
    logic [2:0] q_s;
    logic [2:0] tc_s;

    int errors = 0;
    int checks = 0;

    always #25 clk = ~clk;

    clk_div_by_10 #(.DIVISOR(10)) u_d10 (
        .clk        (clk),
        .reset      (reset),
        .clk_div_10 (q10),
        .tc         (tc10)
    );

    clk_div_by_10 #(.DIVISOR(2)) u_d2 (
        .clk        (clk),
        .reset      (reset),
        .clk_div_10 (q_s[0]),
        .tc         (tc_s[0])
    );

    clk_div_by_10 #(.DIVISOR(4)) u_d4 (
        .clk        (clk),
        .reset      (reset),
        .clk_div_10 (q_s[1]),
        .tc         (tc_s[1])
    );

    clk_div_by_10 #(.DIVISOR(16)) u_d16 (
        .clk        (clk),
        .reset      (reset),
        .clk_div_10 (q_s[2]),
        .tc         (tc_s[2])
    );

    typedef struct {
        logic rst;
        logic q;
        logic tc;
    } vec_t;

    vec_t tab[24];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sweep(input int i, input int d);
        bit found;
        logic p;
        int hi;
        int lo;
        int sp;
        found = 0;
        for (int n = 0; n < 4 * d && !found; n++) begin
            p = q_s[i];
            step();
            if (!p && q_s[i]) found = 1;
        end
        chk($sformatf("sweep%0d_rise", d), int'(found), 1);
        hi = 0;
        while (q_s[i] && hi < 64) begin
            hi++;
            step();
        end
        lo = 0;
        while (!q_s[i] && lo < 64) begin
            lo++;
            step();
        end
        chk($sformatf("sweep%0d_high", d), hi, d / 2);
        chk($sformatf("sweep%0d_low", d), lo, d / 2);
        found = 0;
        for (int n = 0; n < 2 * d + 2 && !found; n++) begin
            if (tc_s[i]) found = 1;
            else step();
        end
        chk($sformatf("sweep%0d_tc_seen", d), int'(found), 1);
        sp = 0;
        do begin
            step();
            sp++;
        end while (!tc_s[i] && sp < 64);
        chk($sformatf("sweep%0d_tc_period", d), sp, d);
    endtask

    initial begin
        int tcs;
        int his;
        int k;

        // reset hold, 4 cycles
        for (int i = 0; i < 4; i++) tab[i] = '{1'b1, 1'b0, 1'b0};
        // edges 1..20 after release (DIVISOR=10)
        tab[4]  = '{1'b0, 1'b0, 1'b0};
        tab[5]  = '{1'b0, 1'b0, 1'b0};
        tab[6]  = '{1'b0, 1'b0, 1'b0};
        tab[7]  = '{1'b0, 1'b0, 1'b0};
        tab[8]  = '{1'b0, 1'b1, 1'b0};
        tab[9]  = '{1'b0, 1'b1, 1'b0};
        tab[10] = '{1'b0, 1'b1, 1'b0};
        tab[11] = '{1'b0, 1'b1, 1'b0};
        tab[12] = '{1'b0, 1'b1, 1'b0};
        tab[13] = '{1'b0, 1'b0, 1'b1};
        tab[14] = '{1'b0, 1'b0, 1'b0};
        tab[15] = '{1'b0, 1'b0, 1'b0};
        tab[16] = '{1'b0, 1'b0, 1'b0};
        tab[17] = '{1'b0, 1'b0, 1'b0};
        tab[18] = '{1'b0, 1'b1, 1'b0};
        tab[19] = '{1'b0, 1'b1, 1'b0};
        tab[20] = '{1'b0, 1'b1, 1'b0};
        tab[21] = '{1'b0, 1'b1, 1'b0};
        tab[22] = '{1'b0, 1'b1, 1'b0};
        tab[23] = '{1'b0, 1'b0, 1'b1};

        for (int i = 0; i < 24; i++) begin
            reset = tab[i].rst;
            step();
            chk($sformatf("tab%0d_q", i), int'(q10), int'(tab[i].q));
            chk($sformatf("tab%0d_tc", i), int'(tc10), int'(tab[i].tc));
            if (tab[i].rst) begin
                chk($sformatf("tab%0d_sweep_q", i), int'(q_s), 0);
                chk($sformatf("tab%0d_sweep_tc", i), int'(tc_s), 0);
            end
        end

        // six further periods, edges 21..80
        tcs = 0;
        his = 0;
        for (k = 21; k <= 80; k++) begin
            step();
            chk($sformatf("ss%0d_q", k), int'(q10), int'(k % 10 >= 5));
            chk($sformatf("ss%0d_tc", k), int'(tc10), int'(k % 10 == 0));
            tcs += int'(tc10);
            his += int'(q10);
        end
        chk("ss_tc_count", tcs, 6);
        chk("ss_high_cycles", his, 30);

        // one-cycle reset three edges after the rise at edge 85
        for (k = 81; k <= 88; k++) step();
        chk("mid_pre_q", int'(q10), 1);
        reset = 1'b1;
        step();
        chk("mid_rst_q", int'(q10), 0);
        chk("mid_rst_tc", int'(tc10), 0);
        reset = 1'b0;
        for (k = 1; k <= 5; k++) begin
            step();
            chk($sformatf("mid_rel%0d_q", k), int'(q10), int'(k == 5));
        end

        sweep(0, 2);
        sweep(1, 4);
        sweep(2, 16);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
